addsub16_pipe: RTL and testbench
================================

// Module: addsub16_pipe
// PURPOSE
//  Registered, flow-controlled front end for the 16-bit combinational add/sub core adder_16bit_s.
//  Accepts operand beats over a valid/ready handshake and registers them into stage 1.
//  The core evaluates stage 1; stage 2 captures SUM/C_out/O plus zero/negative flags.
//  Keeps a sticky overflow flag and a saturating overflow counter for datapath monitoring.
// PARAMETERS
//  W        16  operand/result width; fixed by adder_16bit_s, no other value supported
//  CNT_W    16  width of overflow event counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_a       in   W      operand A
//  in_b       in   W      operand B
//  in_sub     in   1      1: A-B, 0: A+B (drives core Add_ctrl directly)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_sum    out  W      SUM from core
//  out_cout   out  1      C_out (subtract: 1 = no borrow)
//  out_ovf    out  1      O, two's-complement overflow
//  out_zero   out  1      out_sum == 0
//  out_neg    out  1      out_sum[W-1]
//  ovf_sticky out  1      set by any delivered overflow result, held until ovf_clr
//  ovf_cnt    out  CNT_W  count of delivered results with out_ovf=1, saturates at all-ones
//  ovf_clr    in   1      synchronous clear of ovf_sticky and ovf_cnt
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, out_sum/out_cout/out_ovf/out_zero/out_neg=0,
//    ovf_sticky=0, ovf_cnt=0. in_ready=1 one cycle after reset release.
//  - Transfer on valid&&ready at a rising clk edge. A valid beat is never dropped or duplicated.
//    Payload is not changed while valid && !ready. Results leave in acceptance order.
//  - Stage advance: s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv.
//    in_ready = s1_adv (combinational from out_ready, no bubble).
//  - Latency: a beat accepted at edge N has out_valid=1 after edge N+1 when unstalled.
//    Throughput is 1 beat/cycle.
//  - Buffering: max 2 beats in flight. With out_ready held low, in_ready drops once s1 and s2 are both full.
//  - Arithmetic: the core computes A + (B ^ {W{sub}}) + sub. C_out is the raw carry out of bit W-1.
//    O = carry(W-1) ^ carry(W). zero/neg are taken from the registered sum.
//  - Counting happens on result delivery (out_valid && out_ready && out_ovf), not on acceptance:
//    ovf_sticky<=1; ovf_cnt<=ovf_cnt+1, held at all-ones.
//  - ovf_clr in the same cycle as a counted delivery: clear first, then count.
//    Result is ovf_cnt=1, ovf_sticky=1.
//  - ovf_clr alone: ovf_cnt=0, ovf_sticky=0 next cycle. Pipeline contents are unaffected.
//  - Reset asserted mid-operation: all in-flight beats are discarded and every output returns to
//    its reset value immediately, asynchronously.
//  - in_valid is ignored during reset.
// STRUCTURE
//  - Shared header addsub_defs.vh: `define ADDSUB_W 16, ADDSUB_OP_ADD 1'b0, ADDSUB_OP_SUB 1'b1.
//  - Sub-module: one instance of the existing adder_16bit_s between s1 and s2 regs (u_core).
//  - Local logic: two pipeline register banks plus valid bits, the advance terms, and
//    saturating counter and sticky flag regs. Expected size is about 150 lines.
// TESTING
//  1. Add 7FFF+0001, out_ready=1 -> 2 cycles later: sum=8000, cout=0, ovf=1, neg=1, zero=0.
//     ovf_cnt=1, ovf_sticky=1.
//  2. Sub 0005-0005 -> sum=0000, cout=1, ovf=0, zero=1, neg=0.
//     Sub 0000-0001 -> sum=FFFF, cout=0, ovf=0, neg=1.
//  3. Sub 8000-0001 -> sum=7FFF, cout=1, ovf=1. Add FFFF+0001 -> sum=0000, cout=1, ovf=0, zero=1.
//  4. Stream 6 beats back-to-back with out_ready low for cycles 2-5.
//     in_ready=0 after 2 beats are held; all 6 results arrive in order with no loss or duplicate.
//  5. Preload ovf_cnt to FFFE via 65534 overflow beats, then 3 more -> ovf_cnt stays FFFF.
//     ovf_clr together with an overflow delivery -> ovf_cnt=0001.
//  6. Assert rst_n low with 2 beats in flight -> out_valid=0 and all outputs 0 immediately.
//     After release, the next beat yields a correct result with latency 2.

Source files
------------

// File: rtl/addsub16_pipe_pkg.sv
// Shared widths, operation encodings and the stage-2 result record
// for the addsub16_pipe front end and its adder core.
package addsub16_pipe_pkg;

    localparam int   ADDSUB_W      = 16;
    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    typedef struct packed {
        logic [ADDSUB_W-1:0] sum;
        logic                cout;
        logic                ovf;
        logic                zero;
        logic                neg;
    } result_t;

endpackage

// File: rtl/addsub16_pipe_core.sv
// Combinational 16-bit add/sub core: SUM = A + (B ^ {16{Add_ctrl}}) + Add_ctrl.
// C_out is the raw carry out of the MSB; O compares carries into and out of the MSB.
module adder_16bit_s
    import addsub16_pipe_pkg::*;
(
    input  logic [ADDSUB_W-1:0] A,
    input  logic [ADDSUB_W-1:0] B,
    input  logic                Add_ctrl,
    output logic [ADDSUB_W-1:0] SUM,
    output logic                C_out,
    output logic                O
);

    logic [ADDSUB_W-1:0] b_x;
    logic [ADDSUB_W-1:0] low_sum;
    logic [1:0]          msb_sum;
    logic                c_msb;

    assign b_x = B ^ {ADDSUB_W{Add_ctrl == ADDSUB_OP_SUB}};

    // Split at the MSB so the carry into bit W-1 is visible for overflow.
    assign low_sum = {1'b0, A[ADDSUB_W-2:0]} + {1'b0, b_x[ADDSUB_W-2:0]}
                   + {{(ADDSUB_W-1){1'b0}}, Add_ctrl};
    assign c_msb   = low_sum[ADDSUB_W-1];
    assign msb_sum = {1'b0, A[ADDSUB_W-1]} + {1'b0, b_x[ADDSUB_W-1]} + {1'b0, c_msb};

    assign SUM   = {msb_sum[0], low_sum[ADDSUB_W-2:0]};
    assign C_out = msb_sum[1];
    assign O     = c_msb ^ msb_sum[1];

endmodule

// File: rtl/addsub16_pipe.sv
// Two-stage valid/ready wrapper around adder_16bit_s with result flags,
// a sticky overflow flag and a saturating count of delivered overflows.
module addsub16_pipe
    import addsub16_pipe_pkg::*;
#(
    parameter int W     = ADDSUB_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic          rdy_en;
    logic          s1_adv;
    logic          s2_adv;
    logic          vld_p1;
    logic [W-1:0]  a_p1;
    logic [W-1:0]  b_p1;
    logic          sub_p1;
    logic          vld_p2;
    result_t       res_p2;
    logic [W-1:0]  core_sum;
    logic          core_cout;
    logic          core_ovf;
    logic          deliver_ovf;
    logic [CNT_W-1:0] cnt_nxt;
    logic          sticky_nxt;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    // rdy_en keeps the input closed until the first edge after reset release.
    assign in_ready = rdy_en && s1_adv;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_adv) vld_p1 <= in_valid && in_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_p1   <= in_a;
            b_p1   <= in_b;
            sub_p1 <= in_sub;
        end
    end

    adder_16bit_s u_core (
        .A        (a_p1),
        .B        (b_p1),
        .Add_ctrl (sub_p1),
        .SUM      (core_sum),
        .C_out    (core_cout),
        .O        (core_ovf)
    );

    // Stage 2: result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2.sum  <= core_sum;
                res_p2.cout <= core_cout;
                res_p2.ovf  <= core_ovf;
                res_p2.zero <= (core_sum == '0);
                res_p2.neg  <= core_sum[W-1];
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_sum   = res_p2.sum;
    assign out_cout  = res_p2.cout;
    assign out_ovf   = res_p2.ovf;
    assign out_zero  = res_p2.zero;
    assign out_neg   = res_p2.neg;

    assign deliver_ovf = vld_p2 && out_ready && res_p2.ovf;

    // A clear coincident with a counted delivery leaves exactly that one event.
    always_comb begin
        cnt_nxt    = ovf_cnt;
        sticky_nxt = ovf_sticky;
        if (ovf_clr) begin
            cnt_nxt    = deliver_ovf ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            sticky_nxt = deliver_ovf;
        end else if (deliver_ovf) begin
            cnt_nxt    = sat_inc(ovf_cnt);
            sticky_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            ovf_cnt    <= cnt_nxt;
            ovf_sticky <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_addsub16_pipe.sv
// Directed bench for addsub16_pipe: arithmetic corners, backpressure,
// counter saturation and clear, and asynchronous reset mid-flight.
module tb_addsub16_pipe;
    import addsub16_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sub = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_ready = 1'b1;
    logic        ovf_clr = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_cout, out_ovf, out_zero, out_neg, ovf_sticky;
    logic [15:0] ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    addsub16_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .ovf_sticky (ovf_sticky),
        .ovf_cnt    (ovf_cnt),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one beat for one rising edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [15:0] sum, input logic cout,
                             input logic ovf, input logic zero, input logic neg);
        chk({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
        chk(tag, {12'h0, out_sum, out_cout, out_ovf, out_zero, out_neg},
                 {12'h0, sum, cout, ovf, zero, neg});
    endtask

    logic [15:0] s_a   [6];
    logic [15:0] s_b   [6];
    logic        s_sub [6];
    logic [15:0] s_exp [6];

    initial begin
        int sent, recv, first_block, acc, guard;
        logic fire_in, fire_out;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_outputs", {27'h0, out_cout, out_ovf, out_zero, out_neg, ovf_sticky}, 32'h0);
        chk("rst_sum_cnt", {out_sum, ovf_cnt}, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'(1'b1));

        // Single beats with out_ready high
        send(16'h7FFF, 16'h0001, ADDSUB_OP_ADD);
        chk("lat1_not_yet", 32'(out_valid), 32'(1'b0));
        @(negedge clk);
        check_res("add_7fff_1", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("cnt_after_t1", {15'h0, ovf_sticky, ovf_cnt}, {15'h0, 1'b1, 16'h0001});
        chk("drained_t1", 32'(out_valid), 32'(1'b0));

        send(16'h0005, 16'h0005, ADDSUB_OP_SUB);
        @(negedge clk);
        check_res("sub_5_5", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        send(16'h0000, 16'h0001, ADDSUB_OP_SUB);
        @(negedge clk);
        check_res("sub_0_1", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        send(16'h8000, 16'h0001, ADDSUB_OP_SUB);
        @(negedge clk);
        check_res("sub_8000_1", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        send(16'hFFFF, 16'h0001, ADDSUB_OP_ADD);
        @(negedge clk);
        check_res("add_ffff_1", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("cnt_after_t3", 32'(ovf_cnt), 32'h2);

        // Six-beat stream, out_ready low for cycles 2..5
        s_a[0] = 16'h0001; s_b[0] = 16'h0001; s_sub[0] = 1'b0; s_exp[0] = 16'h0002;
        s_a[1] = 16'h0010; s_b[1] = 16'h0003; s_sub[1] = 1'b1; s_exp[1] = 16'h000D;
        s_a[2] = 16'h1234; s_b[2] = 16'h1111; s_sub[2] = 1'b0; s_exp[2] = 16'h2345;
        s_a[3] = 16'h0100; s_b[3] = 16'h0200; s_sub[3] = 1'b1; s_exp[3] = 16'hFF00;
        s_a[4] = 16'h7000; s_b[4] = 16'h1000; s_sub[4] = 1'b0; s_exp[4] = 16'h8000;
        s_a[5] = 16'hFFFE; s_b[5] = 16'h0001; s_sub[5] = 1'b0; s_exp[5] = 16'hFFFF;
        sent = 0; recv = 0; first_block = -1;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_a = s_a[sent]; in_b = s_b[sent]; in_sub = s_sub[sent];
            end
            #1;
            if (in_valid && !in_ready && first_block < 0) first_block = sent - recv;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                chk($sformatf("stream_%0d", recv), 32'(out_sum), 32'(s_exp[recv]));
                recv++;
            end
            @(posedge clk);
            if (fire_in) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_recv_count", 32'(recv), 32'd6);
        chk("stream_block_depth", 32'(first_block), 32'd2);
        @(negedge clk);
        chk("stream_no_dup", 32'(out_valid), 32'(1'b0));
        chk("cnt_after_stream", 32'(ovf_cnt), 32'h3);

        // ovf_clr alone
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_alone", {15'h0, ovf_sticky, ovf_cnt}, 32'h0);

        // Saturation: 65534 overflow beats, then 3 more
        in_a = 16'h7FFF; in_b = 16'h0001; in_sub = ADDSUB_OP_ADD; in_valid = 1'b1;
        acc = 0; guard = 0;
        while (acc < 65534 && guard < 70000) begin
            fire_in = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (fire_in) acc++;
            if (acc == 65534) in_valid = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        chk("preload_accepted", 32'(acc), 32'd65534);
        repeat (3) @(negedge clk);
        chk("cnt_fffe", {15'h0, ovf_sticky, ovf_cnt}, {15'h0, 1'b1, 16'hFFFE});
        repeat (3) begin
            send(16'h7FFF, 16'h0001, ADDSUB_OP_ADD);
            repeat (2) @(negedge clk);
        end
        chk("cnt_saturated", 32'(ovf_cnt), 32'h0000FFFF);

        // ovf_clr coinciding with an overflow delivery
        send(16'h7FFF, 16'h0001, ADDSUB_OP_ADD);
        @(negedge clk);
        chk("clr_dlv_valid", {30'h0, out_valid, out_ovf}, 32'h3);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_with_delivery", {15'h0, ovf_sticky, ovf_cnt}, {15'h0, 1'b1, 16'h0001});

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, ADDSUB_OP_ADD);
        send(16'h7FFF, 16'h7FFF, ADDSUB_OP_ADD);
        chk("two_in_flight", {30'h0, out_valid, in_ready}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("arst_outputs", {out_sum, 11'h0, out_cout, out_ovf, out_zero, out_neg, ovf_sticky},
                            32'h0);
        chk("arst_cnt", 32'(ovf_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'(1'b0));
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 32'(1'b1));
        send(16'h1234, 16'h4321, ADDSUB_OP_SUB);
        chk("post_rst_lat1", 32'(out_valid), 32'(1'b0));
        @(negedge clk);
        check_res("post_rst_sub", 16'hCF13, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("post_rst_drained", 32'(out_valid), 32'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
